// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with programmable wait states.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              cur_write;
  logic [2:0]        cur_f3;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              illegal;
  logic              misalign;
  logic              acc_err;
  logic [31:0]       load_data;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       wdata_lane;

  // State, wait counter, captured request and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  // Next state and wait-state countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake, access decode, lane formatting and response capture.
  always_comb begin
    req_ready  = (state_q == S_IDLE) && !rst;
    accept     = req_valid && req_ready;
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    write_d  = accept ? req_write  : write_q;
    funct3_d = accept ? req_funct3 : funct3_q;
    addr_d   = accept ? req_addr   : addr_q;
    wdata_d  = accept ? req_wdata  : wdata_q;

    // With no wait states the access completes on the accept edge itself.
    cur_write = (state_q == S_IDLE) ? req_write  : write_q;
    cur_f3    = (state_q == S_IDLE) ? req_funct3 : funct3_q;
    cur_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;

    illegal = cur_write ? (cur_f3 > 3'd2)
                        : (cur_f3 == 3'd3 || cur_f3 > 3'd5);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (cur_f3[1:0] == 2'd1 && cur_addr[0])
            || (cur_f3[1:0] == 2'd2 && cur_addr[1:0] != 2'd0);
`else
    misalign = 1'b0;
`endif
    acc_err = illegal || misalign;

    widx     = cur_addr[ADDR_W-1:2];
    word     = mem[widx];
    byte_sel = word[{cur_addr[1:0], 3'b000} +: 8];
    half_sel = cur_addr[1] ? word[31:16] : word[15:0];

    load_data = 32'd0;
    unique case (cur_f3)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = word;
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase

    mem_be     = 4'b0000;
    wdata_lane = cur_wdata;
    unique case (cur_f3)
      3'd0: begin
        mem_be     = 4'b0001 << cur_addr[1:0];
        wdata_lane = {4{cur_wdata[7:0]}};
      end
      3'd1: begin
        mem_be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{cur_wdata[15:0]}};
      end
      3'd2:    mem_be = 4'b1111;
      default: mem_be = 4'b0000;
    endcase
    mem_we = enter_resp && cur_write && !acc_err;

    valid_d = (state_d == S_RESP);
    if (enter_resp) begin
      rdata_d = (cur_write || acc_err) ? 32'd0 : load_data;
      err_d   = acc_err;
    end else if (state_d == S_RESP) begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end else begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  // Byte-lane writes into the storage array; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state and
// one with none, driven in turn through the same scenario list.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        rv_a, rv_b, rr_a, rr_b;
  logic        qr_a, qr_b, vl_a, vl_b, er_a, er_b;
  logic [31:0] rd_a, rd_b;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int vectors;
  int miscompares;
  int wcyc;

  assign rv_a = req_valid && !sel;
  assign rv_b = req_valid &&  sel;
  assign rr_a = rsp_ready && !sel;
  assign rr_b = rsp_ready &&  sel;
  assign req_ready = sel ? qr_b : qr_a;
  assign rsp_valid = sel ? vl_b : vl_a;
  assign rsp_rdata = sel ? rd_b : rd_a;
  assign rsp_err   = sel ? er_b : er_a;

  dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst),
    .req_valid(rv_a), .req_ready(qr_a), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vl_a), .rsp_ready(rr_a), .rsp_rdata(rd_a), .rsp_err(er_a)
  );

  dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(rv_b), .req_ready(qr_b), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vl_b), .rsp_ready(rr_b), .rsp_rdata(rd_b), .rsp_err(er_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, input int stall);
    int lat;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(wcyc + 1));
    chk({tag, ".rdata"}, rsp_rdata, er);
    chk({tag, ".err"}, 32'(rsp_err), 32'(ee));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, er);
      chk({tag, ".hold_err"}, 32'(rsp_err), 32'(ee));
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic suite();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    txn("sw_010", 1, 3'd2, 12'h010, 32'hDEADBEEF, 32'h0, 0, 0);
    txn("lw_010", 0, 3'd2, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0);
    txn("lb_013", 0, 3'd0, 12'h013, 32'h0, 32'hFFFFFFDE, 0, 0);
    txn("lbu_013", 0, 3'd4, 12'h013, 32'h0, 32'h000000DE, 0, 0);
    txn("lh_012", 0, 3'd1, 12'h012, 32'h0, 32'hFFFFDEAD, 0, 0);
    txn("lhu_010", 0, 3'd5, 12'h010, 32'h0, 32'h0000BEEF, 0, 0);
    txn("sb_011", 1, 3'd0, 12'h011, 32'hFFFFFF55, 32'h0, 0, 0);
    txn("lw_sb", 0, 3'd2, 12'h010, 32'h0, 32'hDEAD55EF, 0, 0);
    txn("sh_012", 1, 3'd1, 12'h012, 32'hFFFF1234, 32'h0, 0, 0);
    txn("lw_sh", 0, 3'd2, 12'h010, 32'h0, 32'h123455EF, 0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    txn("lw_012_mis", 0, 3'd2, 12'h012, 32'h0, 32'h0, 1, 0);
    txn("sw_011_mis", 1, 3'd2, 12'h011, 32'h5, 32'h0, 1, 0);
    txn("lw_after_mis", 0, 3'd2, 12'h010, 32'h0, 32'h123455EF, 0, 0);
    txn("lh_011_mis", 0, 3'd1, 12'h011, 32'h0, 32'h0, 1, 0);
`else
    txn("lw_012_al", 0, 3'd2, 12'h012, 32'h0, 32'h123455EF, 0, 0);
    txn("lh_011_al", 0, 3'd1, 12'h011, 32'h0, 32'h000055EF, 0, 0);
    txn("sw_011_al", 1, 3'd2, 12'h011, 32'h5, 32'h0, 0, 0);
    txn("lw_after_al", 0, 3'd2, 12'h010, 32'h0, 32'h00000005, 0, 0);
    txn("sw_restore", 1, 3'd2, 12'h010, 32'h123455EF, 32'h0, 0, 0);
`endif
    txn("ld_f3_3", 0, 3'd3, 12'h010, 32'h0, 32'h0, 1, 5);
    txn("ld_f3_7", 0, 3'd7, 12'h010, 32'h0, 32'h0, 1, 0);
    txn("st_f3_4", 1, 3'd4, 12'h010, 32'hFFFFFFFF, 32'h0, 1, 0);
    txn("lw_after_ill", 0, 3'd2, 12'h010, 32'h0, 32'h123455EF, 0, 0);

    txn("sw_020_init", 1, 3'd2, 12'h020, 32'h11111111, 32'h0, 0, 0);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 12'h020;
    req_wdata  = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_valid", 32'(rsp_valid), (wcyc == 0) ? 32'd1 : 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk); #1;
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    txn("lw_020", 0, 3'd2, 12'h020, 32'h0,
        (wcyc == 0) ? 32'hAAAAAAAA : 32'h11111111, 0, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    sel         = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 12'h000;
    req_wdata   = 32'h0;
    rsp_ready   = 1'b0;

    wcyc = 1;
    sel  = 1'b0;
    suite();

    wcyc = 0;
    sel  = 1'b1;
    suite();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
